// File: rtl/button_event.sv
// button_event: turns a debounced button level into PRESS/RELEASE/LONG/REPEAT events in a one-entry valid/ack register.
// Define BUTTON_EVENT_REPEAT_EN to enable REPEAT events while the button is held past LONG.
module button_event #(
    parameter int                 CNT_W      = 24,
    parameter logic [CNT_W-1:0]   LONG_CNT   = 24'd1000,
    parameter logic [CNT_W-1:0]   REPEAT_CNT = 24'd200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       level_in,
    output logic       ev_valid,
    output logic [1:0] ev_code,
    input  logic       ev_ack,
    output logic       ev_overrun,
    output logic       held
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRESSED = 2'd1;
    localparam logic [1:0] S_LONG    = 2'd2;
    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;
    localparam logic [CNT_W-1:0] LONG_TERM   = LONG_CNT - 1'b1;
    localparam logic [CNT_W-1:0] REPEAT_TERM = REPEAT_CNT - 1'b1;

    if (LONG_CNT == '0 || REPEAT_CNT == '0) begin : g_param_check
        $error("button_event: LONG_CNT and REPEAT_CNT must be at least 1");
    end

    logic [1:0]       state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             new_ev;
    logic [1:0]       new_code;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        new_ev    = 1'b0;
        new_code  = EV_PRESS;
        if (state == S_IDLE) begin
            if (level_in) begin
                nxt_state = S_PRESSED;
                nxt_cnt   = '0;
                new_ev    = 1'b1;
            end
        end else if (!level_in) begin
            // release beats any terminal count reached in the same cycle
            nxt_state = S_IDLE;
            nxt_cnt   = '0;
            new_ev    = 1'b1;
            new_code  = EV_RELEASE;
        end else if (state == S_PRESSED) begin
            if (cnt == LONG_TERM) begin
                nxt_state = S_LONG;
                nxt_cnt   = '0;
                new_ev    = 1'b1;
                new_code  = EV_LONG;
            end else begin
                nxt_cnt = cnt + 1'b1;
            end
        end else begin
`ifdef BUTTON_EVENT_REPEAT_EN
            if (cnt == REPEAT_TERM) begin
                nxt_cnt  = '0;
                new_ev   = 1'b1;
                new_code = EV_REPEAT;
            end else begin
                nxt_cnt = cnt + 1'b1;
            end
`else
            nxt_cnt = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            held       <= 1'b0;
            ev_valid   <= 1'b0;
            ev_code    <= EV_PRESS;
            ev_overrun <= 1'b0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            held  <= nxt_state != S_IDLE;
            if (new_ev && (!ev_valid || ev_ack)) begin
                ev_valid <= 1'b1;
                ev_code  <= new_code;
            end else if (new_ev) begin
                ev_overrun <= 1'b1;
            end else if (ev_ack) begin
                ev_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: randomized and directed stimulus against a hold-time based reference model with a code scoreboard.
module tb_button_event;
    localparam int LC = 8;
    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       level_in = 1'b0;
    logic       ev_ack = 1'b1;
    logic       ev_valid, ev_overrun, held;
    logic [1:0] ev_code;

    button_event #(.CNT_W(24), .LONG_CNT(24'd8), .REPEAT_CNT(24'd4)) dut (
        .clk(clk), .reset(reset), .level_in(level_in), .ev_valid(ev_valid),
        .ev_code(ev_code), .ev_ack(ev_ack), .ev_overrun(ev_overrun), .held(held)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] q[$];
    bit         m_valid = 0, m_ovr = 0, m_held = 0, armed = 0, rst_last = 0;
    int         start = 0, edge_n = 0;

    task automatic chk(input string n, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference: events follow from how long the button has been held since the PRESS edge.
    always @(posedge clk) begin
        int         e;
        bit         has;
        logic [1:0] code;
        edge_n++;
        has  = 0;
        code = 2'b00;
        if (reset) begin
            m_held = 0; m_valid = 0; m_ovr = 0; q.delete(); armed = 1; rst_last = 1;
        end else begin
            rst_last = 0;
            e = edge_n - start;
            if (!m_held && level_in) begin
                has = 1; code = 2'b00; m_held = 1; start = edge_n;
            end else if (m_held && !level_in) begin
                has = 1; code = 2'b01; m_held = 0;
            end else if (m_held && e == LC) begin
                has = 1; code = 2'b10;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            else if (m_held && e > LC && (e - LC) % RC == 0) begin
                has = 1; code = 2'b11;
            end
`endif
            if (has) begin
                if (!m_valid || ev_ack) begin
                    m_valid = 1;
                    q.push_back(code);
                end else begin
                    m_ovr = 1;
                end
            end else if (ev_ack) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] exp;
        if (armed) begin
            chk("valid", {1'b0, ev_valid}, {1'b0, m_valid});
            chk("held", {1'b0, held}, {1'b0, m_held});
            chk("overrun", {1'b0, ev_overrun}, {1'b0, m_ovr});
            if (rst_last) chk("code_reset", ev_code, 2'b00);
            if (ev_valid && ev_ack && !reset) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL code_unexpected got=%0h exp=none at %0t", ev_code, $time);
                end else begin
                    exp = q.pop_front();
                    chk("code", ev_code, exp);
                end
            end
        end
    end

    task automatic cyc(input logic l, input logic a, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            level_in = l;
            ev_ack   = a;
            reset    = r;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc(0, 1, 1, 3);
        cyc(0, 1, 0, 6);
        cyc(1, 1, 0, 4);
        cyc(0, 1, 0, 5);
        cyc(1, 1, 0, 21);
        cyc(0, 1, 0, 5);
        cyc(0, 0, 0, 2);
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 2);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 3);
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 3);
        cyc(1, 1, 0, 5);
        cyc(1, 1, 1, 2);
        cyc(1, 1, 0, 12);
        cyc(0, 1, 0, 4);
        for (int k = 0; k < 40; k++) begin
            int len;
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++)
                cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1);
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++)
                cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0, 1);
        end
        cyc(0, 1, 0, 5);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
